// File: rtl/seg_scan_decoder.sv
// ---------------------------------------------------------------------------
// seg_scan_decoder
//
// Watches the multiplexed 7-segment drive bus from the far end and rebuilds
// the frame that is actually on the display: hundreds, tens, units and the
// raw alarm glyph. A digit observation is accepted only after the bus has
// held one legal pattern for STABLE_CYCLES consecutive samples. A frame is
// published only for an uninterrupted h,t,u,alarm sequence of accepts.
//
// Ports
//   clk_100MHz    : system clock, rising edge
//   reset_n       : asynchronous active-low reset
//   anodes[7:0]   : active-low digit selects, [7]=h [6]=t [5]=u [4]=alarm,
//                   [3:0] must be 1
//   cathodes[7:0] : active-low segments {a,b,c,d,e,f,g,dp}, dp ignored
//   dig_h/t/u     : decoded BCD, 4'hF when blank or illegal
//   blank_h/t/u   : digit was blank (all segments off)
//   alarm_seg     : raw cathode byte captured for the alarm digit
//   frame_valid   : one-cycle pulse when the outputs above update
//   seg_error     : some h/t/u pattern in the published frame was illegal
//   scan_timeout  : no frame published for TIMEOUT_CYCLES clocks
// ---------------------------------------------------------------------------
module seg_scan_decoder #(
    parameter int STABLE_CYCLES  = 16,
    parameter int TIMEOUT_CYCLES = 1_000_000
) (
    input  logic       clk_100MHz,
    input  logic       reset_n,
    input  logic [7:0] anodes,
    input  logic [7:0] cathodes,
    output logic [3:0] dig_h,
    output logic [3:0] dig_t,
    output logic [3:0] dig_u,
    output logic       blank_h,
    output logic       blank_t,
    output logic       blank_u,
    output logic [7:0] alarm_seg,
    output logic       frame_valid,
    output logic       seg_error,
    output logic       scan_timeout
);

    localparam int SW = $clog2(STABLE_CYCLES);
    localparam int TW = $clog2(TIMEOUT_CYCLES);

    localparam logic [SW-1:0] STAB_MAX = SW'(STABLE_CYCLES - 1);
    localparam logic [SW-1:0] STAB_PRE = SW'(STABLE_CYCLES - 2);
    localparam logic [SW-1:0] STAB_ONE = SW'(1);
    localparam logic [TW-1:0] TO_MAX   = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [TW-1:0] TO_ONE   = TW'(1);

    // Slot encoding: {illegal, blank, value[3:0]}
    localparam logic [5:0] SLOT_BLANK = 6'b01_1111;

    typedef enum logic [1:0] {
        SYNC  = 2'd0,
        GOT_H = 2'd1,
        GOT_T = 2'd2,
        GOT_U = 2'd3
    } state_t;

    // Active-low segment pattern {a..g} to {illegal, blank, value}
    function automatic logic [5:0] seg_decode(input logic [6:0] seg);
        logic [5:0] res;
        case (seg)
            7'h01:   res = 6'b00_0000;
            7'h4F:   res = 6'b00_0001;
            7'h12:   res = 6'b00_0010;
            7'h06:   res = 6'b00_0011;
            7'h4C:   res = 6'b00_0100;
            7'h24:   res = 6'b00_0101;
            7'h20:   res = 6'b00_0110;
            7'h0F:   res = 6'b00_0111;
            7'h00:   res = 6'b00_1000;
            7'h04:   res = 6'b00_1001;
            7'h7F:   res = SLOT_BLANK;
            default: res = 6'b10_1111;
        endcase
        return res;
    endfunction

    logic [7:0]    s1_an_q,  s1_an_d;
    logic [7:0]    s1_cat_q, s1_cat_d;
    logic [7:0]    s2_an_q,  s2_an_d;
    logic [7:0]    s2_cat_q, s2_cat_d;
    logic [SW-1:0] stab_cnt_q, stab_cnt_d;
    logic [TW-1:0] to_cnt_q, to_cnt_d;
    state_t        state_q, state_d;
    logic [5:0]    slot_h_q, slot_h_d;
    logic [5:0]    slot_t_q, slot_t_d;
    logic [5:0]    slot_u_q, slot_u_d;
    logic [3:0]    dig_h_q, dig_h_d, dig_t_q, dig_t_d, dig_u_q, dig_u_d;
    logic          blank_h_q, blank_h_d, blank_t_q, blank_t_d, blank_u_q, blank_u_d;
    logic [7:0]    alarm_seg_q, alarm_seg_d;
    logic          frame_valid_q, frame_valid_d;
    logic          seg_error_q, seg_error_d;
    logic          scan_timeout_q, scan_timeout_d;

    logic          is_h_s, is_t_s, is_u_s, is_a_s, an_legal_s, same_s;
    logic          accept_s, publish_s;
    logic [5:0]    dec_s;

    // Input pipeline, stability counter and accept strobe
    always_comb begin
        s1_an_d  = anodes;
        s1_cat_d = cathodes;
        s2_an_d  = s1_an_q;
        s2_cat_d = s1_cat_q;

        // Exact compares also enforce the unused selects [3:0] being high
        is_h_s     = (s1_an_q == 8'h7F);
        is_t_s     = (s1_an_q == 8'hBF);
        is_u_s     = (s1_an_q == 8'hDF);
        is_a_s     = (s1_an_q == 8'hEF);
        an_legal_s = is_h_s | is_t_s | is_u_s | is_a_s;
        same_s     = (s1_an_q == s2_an_q) && (s1_cat_q == s2_cat_q);

        if (!same_s || !an_legal_s) begin
            stab_cnt_d = '0;
        end else if (stab_cnt_q != STAB_MAX) begin
            stab_cnt_d = stab_cnt_q + STAB_ONE;
        end else begin
            stab_cnt_d = stab_cnt_q;
        end

        // Single strobe per dwell: only the PRE->MAX step counts, MAX holds
        accept_s = same_s && an_legal_s && (stab_cnt_q == STAB_PRE);
        dec_s    = seg_decode(s1_cat_q[7:1]);
    end

    // Frame assembly FSM: h -> t -> u -> alarm, any disorder resynchronises
    always_comb begin
        state_d   = state_q;
        slot_h_d  = slot_h_q;
        slot_t_d  = slot_t_q;
        slot_u_d  = slot_u_q;
        publish_s = 1'b0;

        if (!accept_s) begin
            state_d = state_q;
        end else if (is_h_s) begin
            // A hundreds accept always opens a fresh frame
            slot_h_d = dec_s;
            state_d  = GOT_H;
        end else begin
            case (state_q)
                GOT_H: begin
                    if (is_t_s) begin
                        slot_t_d = dec_s;
                        state_d  = GOT_T;
                    end else begin
                        state_d = SYNC;
                    end
                end
                GOT_T: begin
                    if (is_u_s) begin
                        slot_u_d = dec_s;
                        state_d  = GOT_U;
                    end else begin
                        state_d = SYNC;
                    end
                end
                GOT_U: begin
                    if (is_a_s) begin
                        publish_s = 1'b1;
                    end else begin
                        publish_s = 1'b0;
                    end
                    state_d = SYNC;
                end
                default: state_d = SYNC;
            endcase
        end
    end

    // Published outputs and scan timeout
    always_comb begin
        dig_h_d       = dig_h_q;
        dig_t_d       = dig_t_q;
        dig_u_d       = dig_u_q;
        blank_h_d     = blank_h_q;
        blank_t_d     = blank_t_q;
        blank_u_d     = blank_u_q;
        alarm_seg_d   = alarm_seg_q;
        seg_error_d   = seg_error_q;
        frame_valid_d = publish_s;

        if (publish_s) begin
            dig_h_d     = slot_h_q[3:0];
            dig_t_d     = slot_t_q[3:0];
            dig_u_d     = slot_u_q[3:0];
            blank_h_d   = slot_h_q[4];
            blank_t_d   = slot_t_q[4];
            blank_u_d   = slot_u_q[4];
            alarm_seg_d = s1_cat_q;
            seg_error_d = slot_h_q[5] | slot_t_q[5] | slot_u_q[5];
        end else begin
            seg_error_d = seg_error_q;
        end

        // Publish has priority over a timeout landing in the same cycle
        if (publish_s) begin
            to_cnt_d       = '0;
            scan_timeout_d = 1'b0;
        end else if (to_cnt_q == TO_MAX) begin
            to_cnt_d       = to_cnt_q;
            scan_timeout_d = 1'b1;
        end else begin
            to_cnt_d       = to_cnt_q + TO_ONE;
            scan_timeout_d = scan_timeout_q;
        end
    end

    // State registers
    always_ff @(posedge clk_100MHz or negedge reset_n) begin
        if (!reset_n) begin
            s1_an_q        <= 8'hFF;
            s1_cat_q       <= 8'hFF;
            s2_an_q        <= 8'hFF;
            s2_cat_q       <= 8'hFF;
            stab_cnt_q     <= '0;
            to_cnt_q       <= '0;
            state_q        <= SYNC;
            slot_h_q       <= SLOT_BLANK;
            slot_t_q       <= SLOT_BLANK;
            slot_u_q       <= SLOT_BLANK;
            dig_h_q        <= 4'hF;
            dig_t_q        <= 4'hF;
            dig_u_q        <= 4'hF;
            blank_h_q      <= 1'b1;
            blank_t_q      <= 1'b1;
            blank_u_q      <= 1'b1;
            alarm_seg_q    <= 8'hFF;
            frame_valid_q  <= 1'b0;
            seg_error_q    <= 1'b0;
            scan_timeout_q <= 1'b0;
        end else begin
            s1_an_q        <= s1_an_d;
            s1_cat_q       <= s1_cat_d;
            s2_an_q        <= s2_an_d;
            s2_cat_q       <= s2_cat_d;
            stab_cnt_q     <= stab_cnt_d;
            to_cnt_q       <= to_cnt_d;
            state_q        <= state_d;
            slot_h_q       <= slot_h_d;
            slot_t_q       <= slot_t_d;
            slot_u_q       <= slot_u_d;
            dig_h_q        <= dig_h_d;
            dig_t_q        <= dig_t_d;
            dig_u_q        <= dig_u_d;
            blank_h_q      <= blank_h_d;
            blank_t_q      <= blank_t_d;
            blank_u_q      <= blank_u_d;
            alarm_seg_q    <= alarm_seg_d;
            frame_valid_q  <= frame_valid_d;
            seg_error_q    <= seg_error_d;
            scan_timeout_q <= scan_timeout_d;
        end
    end

    assign dig_h        = dig_h_q;
    assign dig_t        = dig_t_q;
    assign dig_u        = dig_u_q;
    assign blank_h      = blank_h_q;
    assign blank_t      = blank_t_q;
    assign blank_u      = blank_u_q;
    assign alarm_seg    = alarm_seg_q;
    assign frame_valid  = frame_valid_q;
    assign seg_error    = seg_error_q;
    assign scan_timeout = scan_timeout_q;

endmodule
